// File: rtl/uart_pwm_pkg.sv
// rtl/uart_pwm_pkg.sv - shared constants and parser state type for the UART duty parser
//
// Purpose: ASCII byte constants, reply-character defaults, duty/accumulator widths
//          and the parser state encoding used by uart_duty_parser.
// Ports:   none (package)
package uart_pwm_pkg;

    localparam int DUTY_W = 8;
    // 10 bits hold 999, the largest three-digit value, so out-of-range
    // commands are seen as out of range rather than wrapping.
    localparam int ACC_W  = 10;

    localparam logic [7:0] CHAR_D      = 8'h44;
    localparam logic [7:0] CHAR_d      = 8'h64;
    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam logic [7:0] CHAR_0      = 8'h30;
    localparam logic [7:0] CHAR_9      = 8'h39;
    localparam logic [7:0] ACK_DEFAULT = 8'h4B;
    localparam logic [7:0] NAK_DEFAULT = 8'h45;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_DISCARD = 2'd2
    } parser_state_e;

endpackage

// File: rtl/uart_reply_buf.sv
// rtl/uart_reply_buf.sv - single-entry valid/ready reply register, first reply wins
//
// Purpose: holds one reply byte for the UART transmitter. A push while a reply
//          is still pending is dropped.
// Ports:   clk, reset (async, active-high)
//          push / push_data   : queue a reply byte
//          tx_data / tx_valid : pending reply, stable while tx_valid=1
//          tx_ready           : transmitter accepts when tx_valid & tx_ready
module uart_reply_buf
    import uart_pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q) begin
            // A push in the same cycle as a pending reply is dropped, even if
            // that reply is being accepted right now.
            if (tx_ready) begin
                valid_d = 1'b0;
            end
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;

endmodule

// File: rtl/uart_duty_parser.sv
// rtl/uart_duty_parser.sv - parses "D<digits><CR|LF>" commands into a PWM duty value
//
// Purpose: consumes UART bytes, validates duty commands (0..MAX_DUTY), drives the
//          PWM duty input and queues an ACK/NAK reply per command.
// Ports:   clk, reset (async, active-high)
//          rx_data/rx_valid/rx_error : received byte strobe, rx_error marks framing error
//          duty / duty_update        : current duty and one-cycle update pulse
//          cmd_error                 : one-cycle pulse per rejected command or byte
//          tx_data/tx_valid/tx_ready : one-entry reply channel to the transmitter
module uart_duty_parser
    import uart_pwm_pkg::*;
#(
    parameter int          MAX_DUTY       = 100,
    parameter int          RESET_DUTY     = 0,
    parameter int          MAX_DIGITS     = 3,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_CHAR       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_CHAR       = NAK_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic              cmd_error,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ACC_W-1:0]  MAX_ACC  = ACC_W'(MAX_DUTY);
    localparam logic [NDIG_W-1:0] MAX_NDIG = NDIG_W'(MAX_DIGITS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    parser_state_e     state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [NDIG_W-1:0] ndig_q, ndig_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_update_q, duty_update_d;
    logic              cmd_error_q, cmd_error_d;

    logic accept_ev;
    logic error_ev;

    // Byte classification; a byte with a framing error is never treated as
    // a command, digit or terminator.
    logic byte_ok, is_cmd, is_term, is_digit;
    assign byte_ok  = rx_valid && !rx_error;
    assign is_cmd   = byte_ok && (rx_data == CHAR_D || rx_data == CHAR_d);
    assign is_term  = byte_ok && (rx_data == CHAR_CR || rx_data == CHAR_LF);
    assign is_digit = byte_ok && (rx_data >= CHAR_0) && (rx_data <= CHAR_9);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and command events
    always_comb begin
        state_d   = state_q;
        accept_ev = 1'b0;
        error_ev  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (is_cmd) begin
                        state_d = ST_DIGITS;
                    end else if (!is_term) begin
                        error_ev = 1'b1;
                    end
                end
            end
            ST_DIGITS: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (ndig_q == MAX_NDIG) begin
                            error_ev = 1'b1;
                            state_d  = ST_DISCARD;
                        end
                    end else if (is_term) begin
                        state_d = ST_IDLE;
                        if (ndig_q != '0 && acc_q <= MAX_ACC) begin
                            accept_ev = 1'b1;
                        end else begin
                            error_ev = 1'b1;
                        end
                    end else begin
                        error_ev = 1'b1;
                        state_d  = ST_DISCARD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // A byte arriving in the expiry cycle takes the branch above.
                    error_ev = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (is_term) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        acc_d         = acc_q;
        ndig_d        = ndig_q;
        tmo_d         = tmo_q;
        duty_d        = duty_q;
        duty_update_d = accept_ev;
        cmd_error_d   = error_ev;

        if (rx_valid || state_q != ST_DIGITS || state_d != ST_DIGITS) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (state_q == ST_IDLE && state_d == ST_DIGITS) begin
            acc_d  = '0;
            ndig_d = '0;
        end else if (state_q == ST_DIGITS && is_digit && ndig_q != MAX_NDIG) begin
            acc_d  = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(rx_data - CHAR_0);
            ndig_d = ndig_q + 1'b1;
        end

        if (accept_ev) begin
            duty_d = acc_q[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            ndig_q        <= '0;
            tmo_q         <= '0;
            duty_q        <= DUTY_W'(RESET_DUTY);
            duty_update_q <= 1'b0;
            cmd_error_q   <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            ndig_q        <= ndig_d;
            tmo_q         <= tmo_d;
            duty_q        <= duty_d;
            duty_update_q <= duty_update_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

    assign duty        = duty_q;
    assign duty_update = duty_update_q;
    assign cmd_error   = cmd_error_q;

    // Accept and error are mutually exclusive, so one push carries either reply.
    uart_reply_buf #(.W(8)) u_reply_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (accept_ev | error_ev),
        .push_data (accept_ev ? ACK_CHAR : NAK_CHAR),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

endmodule
